des_key_sched_rev: RTL and testbench

- Sequential DES key-schedule engine for the decryption direction.
- Accepts one 64-bit DES key and emits the 16 round subkeys in reverse order, K16 first and K1 last, one per valid/ready handshake.
- Produces each next subkey by right-rotating the C/D halves, so no 16-entry subkey store is needed.
- Sits beside the Feistel round datapath and its S-box lookups, feeding the decrypt pass of each 3DES stage.

---
 rtl/des_key_sched_rev.sv | 116 +++++++++++
 tb/tb_des_key_sched_rev.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_rev.sv
// DES key schedule for decryption: emits K16 down to K1, one per handshake,
// by rotating the C/D halves right instead of storing all 16 subkeys.
module des_key_sched_rev (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key_in,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  subkey_round,
  output logic        subkey_last
);

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_reg, state_next;
  logic [27:0] c_reg, c_next;
  logic [27:0] d_reg, d_next;
  logic [3:0]  rnd_reg, rnd_next;

  logic [55:0] pc1_bits;
  logic [55:0] cd_bits;
  logic [47:0] pc2_bits;
  logic        unused_parity;

  // FIPS bit n lives at vector bit (width - n).
  generate
    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
      localparam int SRC = 64 - PC1_TAB[gi];
      assign pc1_bits[55-gi] = key_in[SRC];
    end
    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
      localparam int SRC = 56 - PC2_TAB[gi];
      assign pc2_bits[47-gi] = cd_bits[SRC];
    end
  endgenerate

  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  assign cd_bits      = {c_reg, d_reg};
  assign subkey       = pc2_bits;
  assign subkey_round = rnd_reg;
  assign key_ready    = (state_reg == IDLE);
  assign subkey_valid = (state_reg == EMIT);
  assign subkey_last  = (state_reg == EMIT) && (rnd_reg == 4'd0);

  logic one_step;
  assign one_step = (rnd_reg == 4'd15) || (rnd_reg == 4'd8) || (rnd_reg == 4'd1);

  always_comb begin
    state_next = state_reg;
    c_next     = c_reg;
    d_next     = d_reg;
    rnd_next   = rnd_reg;
    case (state_reg)
      IDLE: begin
        // PC1 output is already K16's C/D: the forward shifts total 28.
        if (key_valid) begin
          c_next     = pc1_bits[55:28];
          d_next     = pc1_bits[27:0];
          rnd_next   = 4'd15;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (subkey_ready) begin
          if (rnd_reg == 4'd0) begin
            state_next = IDLE;
          end else begin
            if (one_step) begin
              c_next = {c_reg[0], c_reg[27:1]};
              d_next = {d_reg[0], d_reg[27:1]};
            end else begin
              c_next = {c_reg[1:0], c_reg[27:2]};
              d_next = {d_reg[1:0], d_reg[27:2]};
            end
            rnd_next = rnd_reg - 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      c_reg     <= '0;
      d_reg     <= '0;
      rnd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      d_reg     <= d_next;
      rnd_reg   <= rnd_next;
    end
  end

endmodule

// File: tb/tb_des_key_sched_rev.sv
// Directed bench for des_key_sched_rev: table of known-answer keys plus
// hand-written backpressure, busy-key, mid-sequence reset and back-to-back cases.
module tb_des_key_sched_rev;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key_in;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  subkey_round;
  logic        subkey_last;

  des_key_sched_rev dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .subkey(subkey), .subkey_round(subkey_round), .subkey_last(subkey_last)
  );

  always #5 clk = ~clk;

  localparam int M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int M_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KEY_T1   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BUSY = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY_B2B  = 64'h0E329232EA6D0D73;

  typedef struct {
    logic [63:0] key;
    logic [47:0] k16;
    logic [47:0] k1;
    bit          uniform;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [47:0] ref_k [16];   // index = round (0 = K1)
  logic [47:0] got   [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Forward FIPS schedule: left rotations from PC1, K1..K16.
  task automatic build_ref(input logic [63:0] k);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - M_PC1[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < M_SHIFT[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[6'(47 - i)] = cd[6'(56 - M_PC2[i])];
      ref_k[r] = ks;
    end
  endtask

  task automatic send_key(input logic [63:0] k);
    bit accepted = 0;
    key_in    = k;
    key_valid = 1'b1;
    for (int cyc = 0; cyc < 50 && !accepted; cyc++) begin
      if (key_ready) accepted = 1;
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    check("key_accept", 64'(accepted), 64'd1);
  endtask

  // Called one cycle after key acceptance; consumes subkeys and checks them.
  task automatic collect(input logic [63:0] k, input int stall_pct, input bit pulse_busy,
                         input int abort_after, output int ntx);
    logic [47:0] prev_sk;
    logic [3:0]  prev_rnd;
    logic        prev_last;
    bit          stalled;
    int          expr;
    int          cyc;
    build_ref(k);
    expr = 15; ntx = 0; stalled = 0; cyc = 0;
    prev_sk = '0; prev_rnd = '0; prev_last = 1'b0;
    check("k16_latency", 64'(subkey_valid), 64'd1);
    while (ntx < 16 && !(abort_after > 0 && ntx == abort_after) && cyc < 300) begin
      subkey_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= 32'(stall_pct));
      if (pulse_busy) begin
        key_valid = (ntx >= 3 && ntx <= 5);
        key_in    = KEY_BUSY;
        if (key_valid) check("busy_key_ready", 64'(key_ready), 64'd0);
      end
      if (stalled) begin
        check("stall_subkey", 64'(subkey), 64'(prev_sk));
        check("stall_round", 64'(subkey_round), 64'(prev_rnd));
        check("stall_last", 64'(subkey_last), 64'(prev_last));
      end
      check("valid", 64'(subkey_valid), 64'd1);
      check("subkey", 64'(subkey), 64'(ref_k[expr]));
      check("round", 64'(subkey_round), 64'(expr));
      check("last", 64'(subkey_last), 64'(expr == 0));
      got[expr] = subkey;
      if (subkey_ready) begin
        $display("xfer key=%h round=%0d subkey=%h last=%0d", k, subkey_round, subkey, subkey_last);
        ntx++;
        expr--;
        stalled = 0;
      end else begin
        stalled = 1;
      end
      prev_sk = subkey; prev_rnd = subkey_round; prev_last = subkey_last;
      @(posedge clk); #1;
      cyc++;
    end
    if (pulse_busy) key_valid = 1'b0;
    if (cyc >= 300) check("collect_timeout", 64'd0, 64'd1);
    if (ntx == 16) begin
      check("done_valid", 64'(subkey_valid), 64'd0);
      check("done_ready", 64'(key_ready), 64'd1);
    end
  endtask

  initial begin
    vec_t vecs [4];
    int n;
    vecs[0] = '{key: KEY_T1,                k16: 48'hCB3D8B0E17F5, k1: 48'h1B02EFFC7072, uniform: 0};
    vecs[1] = '{key: 64'h0101010101010101, k16: 48'h000000000000, k1: 48'h000000000000, uniform: 1};
    vecs[2] = '{key: 64'hFEFEFEFEFEFEFEFE, k16: 48'hFFFFFFFFFFFF, k1: 48'hFFFFFFFFFFFF, uniform: 1};
    vecs[3] = '{key: 64'hFFFFFFFFFFFFFFFF, k16: 48'hFFFFFFFFFFFF, k1: 48'hFFFFFFFFFFFF, uniform: 1};

    rst = 1'b1; key_valid = 1'b0; key_in = '0; subkey_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(key_ready), 64'd1);
    check("rst_valid", 64'(subkey_valid), 64'd0);
    check("rst_round", 64'(subkey_round), 64'd0);
    check("rst_last", 64'(subkey_last), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_valid", 64'(subkey_valid), 64'd0);

    // Known answers, parity-ignored and all-ones keys.
    for (int v = 0; v < 4; v++) begin
      send_key(vecs[v].key);
      collect(vecs[v].key, 0, 0, 0, n);
      check("tx_count", 64'(n), 64'd16);
      check("kat_k16", 64'(got[15]), 64'(vecs[v].k16));
      check("kat_k1", 64'(got[0]), 64'(vecs[v].k1));
      if (vecs[v].uniform)
        for (int r = 1; r < 15; r++) check("uniform", 64'(got[r]), 64'(vecs[v].k16));
    end

    // Random backpressure.
    send_key(KEY_T1);
    collect(KEY_T1, 40, 0, 0, n);
    check("bp_count", 64'(n), 64'd16);

    // Key presented while busy is ignored, then accepted afterwards.
    send_key(KEY_T1);
    collect(KEY_T1, 0, 1, 0, n);
    check("busy_count", 64'(n), 64'd16);
    send_key(KEY_BUSY);
    collect(KEY_BUSY, 0, 0, 0, n);

    // Asynchronous reset after 5 transfers.
    send_key(KEY_T1);
    collect(KEY_T1, 0, 0, 5, n);
    check("abort_count", 64'(n), 64'd5);
    check("pre_rst_round", 64'(subkey_round), 64'd10);
    #1 rst = 1'b1;
    #1;
    check("arst_ready", 64'(key_ready), 64'd1);
    check("arst_valid", 64'(subkey_valid), 64'd0);
    check("arst_round", 64'(subkey_round), 64'd0);
    check("arst_subkey", 64'(subkey), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 64'(subkey_valid), 64'd0);
    send_key(KEY_BUSY);
    collect(KEY_BUSY, 0, 0, 0, n);
    check("restart_count", 64'(n), 64'd16);

    // Back-to-back keys with key_valid held high.
    key_in = KEY_T1; key_valid = 1'b1;
    check("b2b_ready0", 64'(key_ready), 64'd1);
    @(posedge clk); #1;
    key_in = KEY_B2B;
    collect(KEY_T1, 0, 0, 0, n);
    check("b2b_count1", 64'(n), 64'd16);
    @(posedge clk); #1;
    key_valid = 1'b0;
    collect(KEY_B2B, 0, 0, 0, n);
    check("b2b_count2", 64'(n), 64'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
